qam_rx: RTL and testbench



---
 rtl/qam_rx.sv | 103 ++++++++++
 tb/tb_qam_rx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/qam_rx.sv
// qam_rx: fs/4 4-QAM demodulator (mix, integrate-and-dump, sign slicer, 2-bit serialiser)
module qam_rx #(
   parameter int OSR   = 8,
   parameter int SKIP  = 0,
   parameter int ACC_W = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic signed [17:0] IFin,
   output logic               Bout,
   output logic               Bvalid,
   output logic [1:0]         sym,
   output logic               sym_valid
);
   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_INTEG} state_t;
   localparam logic [6:0] K_LAST  = 7'(OSR - 1);
   localparam logic [9:0] SC_LAST = 10'(SKIP == 0 ? 0 : SKIP - 1);
   state_t state_q, state_d;
   logic [1:0] ph_q, ph_d, ph;
   logic [9:0] sc_q, sc_d, sc;
   logic [6:0] k_q, k_d, k;
   logic signed [ACC_W-1:0] acci_q, acci_d, accq_q, accq_d, x, sum_i, sum_q;
   logic [1:0] sym_q, sym_d;
   logic sym_valid_q, sym_valid_d, bout_q, bout_d, bvalid_q, bvalid_d;
   logic pend_q, pend_d, b0_q, b0_d, skipping;
   always_comb begin
      x = {{(ACC_W-18){IFin[17]}}, IFin};
      ph = state_q == S_IDLE ? 2'd0 : ph_q;
      sc = state_q == S_IDLE ? 10'd0 : sc_q;
      k = state_q == S_INTEG ? k_q : 7'd0;
      skipping = SKIP != 0 && state_q != S_INTEG;
      sum_i = acci_q + (ph == 2'd0 ? x : ph == 2'd2 ? -x : '0);
      sum_q = accq_q + (ph == 2'd1 ? x : ph == 2'd3 ? -x : '0);
      state_d = S_IDLE;
      ph_d = '0;
      sc_d = '0;
      k_d = '0;
      acci_d = '0;
      accq_d = '0;
      sym_d = sym_q;
      sym_valid_d = 1'b0;
      bout_d = 1'b0;
      bvalid_d = 1'b0;
      pend_d = 1'b0;
      b0_d = 1'b0;
      if (en) begin
         ph_d = ph + 2'd1;
         bout_d = pend_q & b0_q;
         bvalid_d = pend_q;
         if (skipping) begin
            state_d = sc == SC_LAST ? S_INTEG : S_SKIP;
            sc_d = sc + 10'd1;
         end else if (k == K_LAST) begin
            state_d = S_INTEG;
            sym_d = {sum_i[ACC_W-1], sum_q[ACC_W-1]};
            sym_valid_d = 1'b1;
            bout_d = sum_i[ACC_W-1];
            bvalid_d = 1'b1;
            pend_d = 1'b1;
            b0_d = sum_q[ACC_W-1];
         end else begin
            state_d = S_INTEG;
            k_d = k + 7'd1;
            acci_d = sum_i;
            accq_d = sum_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ph_q <= '0;
         sc_q <= '0;
         k_q <= '0;
         acci_q <= '0;
         accq_q <= '0;
         sym_q <= '0;
         sym_valid_q <= 1'b0;
         bout_q <= 1'b0;
         bvalid_q <= 1'b0;
         pend_q <= 1'b0;
         b0_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q <= ph_d;
         sc_q <= sc_d;
         k_q <= k_d;
         acci_q <= acci_d;
         accq_q <= accq_d;
         sym_q <= sym_d;
         sym_valid_q <= sym_valid_d;
         bout_q <= bout_d;
         bvalid_q <= bvalid_d;
         pend_q <= pend_d;
         b0_q <= b0_d;
      end
   end
   assign Bout = bout_q;
   assign Bvalid = bvalid_q;
   assign sym = sym_q;
   assign sym_valid = sym_valid_q;
endmodule

// File: tb/tb_qam_rx.sv
// tb_qam_rx: directed checks of qam_rx across four parameter sets
module tb_qam_rx;
   logic clk = 1'b0, reset = 1'b1, en = 1'b0;
   logic signed [17:0] ifin = '0;
   logic bout0, bv0, sv0, bout1, bv1, sv1, bout2, bv2, sv2, bout3, bv3, sv3;
   logic [1:0] sym0, sym1, sym2, sym3;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   qam_rx #(.OSR(8), .SKIP(0), .ACC_W(26)) u0 (.clk(clk), .reset(reset), .en(en), .IFin(ifin),
      .Bout(bout0), .Bvalid(bv0), .sym(sym0), .sym_valid(sv0));
   qam_rx #(.OSR(4), .SKIP(0), .ACC_W(26)) u1 (.clk(clk), .reset(reset), .en(en), .IFin(ifin),
      .Bout(bout1), .Bvalid(bv1), .sym(sym1), .sym_valid(sv1));
   qam_rx #(.OSR(128), .SKIP(0), .ACC_W(26)) u2 (.clk(clk), .reset(reset), .en(en), .IFin(ifin),
      .Bout(bout2), .Bvalid(bv2), .sym(sym2), .sym_valid(sv2));
   qam_rx #(.OSR(4), .SKIP(3), .ACC_W(26)) u3 (.clk(clk), .reset(reset), .en(en), .IFin(ifin),
      .Bout(bout3), .Bvalid(bv3), .sym(sym3), .sym_valid(sv3));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic e, input int v);
      en = e;
      ifin = 18'(v);
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      reset = 1'b0;
   endtask
   int p2[4] = '{-500, 500, 500, -500};
   int p00[4] = '{1000, 1000, -1000, -1000};
   int p11[4] = '{-1000, -1000, 1000, 1000};
   int s3[16] = '{1000, 1000, -1000, -1000, -1000, 1000, 1000, -1000,
                  1000, -1000, -1000, 1000, -1000, -1000, 1000, 1000};
   int s5[7] = '{20000, 20000, 20000, 1000, -1000, -1000, 1000};
   logic [1:0] e3[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
   initial begin
      logic early;
      logic [7:0] stream;
      int nbv, t, v;
      early = 1'b0;
      stream = '0;
      nbv = 0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, 5000);
      chk("rst_bout", bout0, 0);
      chk("rst_bvalid", bv0, 0);
      chk("rst_sym", sym0, 0);
      chk("rst_sym_valid", sv0, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 5000);
         if (i < 7) early |= sv0;
      end
      chk("rst_no_early_sv", early, 0);
      chk("rst_first_sv", sv0, 1);
      chk("rst_first_sym", sym0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, p2[i % 4]);
      chk("single_sym", sym0, 2'b10);
      chk("single_sv", sv0, 1);
      chk("single_b1", bout0, 1);
      chk("single_bv1", bv0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 0);
         if (i == 0) begin
            chk("single_b0", bout0, 0);
            chk("single_bv0", bv0, 1);
            chk("single_sv_drop", sv0, 0);
         end
         if (i == 1) chk("single_bv_idle", bv0, 0);
      end
      chk("tie_sym", sym0, 2'b00);
      chk("tie_sv", sv0, 1);
      cyc(1'b0, 0);
      chk("abort_c1_bv", bv0, 0);
      chk("abort_c1_sym", sym0, 2'b00);
      early = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, p00[i % 4] * 20);
         early |= sv0;
      end
      cyc(1'b0, 0);
      early |= sv0;
      chk("abort_no_sv", early, 0);
      chk("abort_sym_held", sym0, 2'b00);
      early = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, p11[i % 4]);
         if (i < 7) early |= sv0;
      end
      chk("restart_no_early", early, 0);
      chk("restart_sym", sym0, 2'b11);
      chk("restart_sv", sv0, 1);
      chk("restart_b1", bout0, 1);
      cyc(1'b1, 0);
      chk("restart_b0", bout0, 1);
      chk("restart_bv0", bv0, 1);
      do_reset();
      for (int i = 0; i < 18; i++) begin
         cyc(1'b1, i < 16 ? s3[i] : 0);
         t = i + 1;
         if (bv1) begin
            nbv++;
            stream = {stream[6:0], bout1};
         end
         if (t % 4 == 0 && t <= 16) begin
            chk($sformatf("b2b_sym%0d", t / 4 - 1), sym1, e3[t / 4 - 1]);
            chk($sformatf("b2b_sv%0d", t / 4 - 1), sv1, 1);
         end
      end
      chk("b2b_stream", stream, 8'b0010_0111);
      chk("b2b_bvalid_count", nbv, 8);
      do_reset();
      for (int i = 0; i < 256; i++) begin
         if (i < 128) v = (i % 4 == 0) ? -131072 : (i % 4 == 2) ? 131071 : 0;
         else v = (i % 4 == 1) ? 131071 : (i % 4 == 2) ? -131072 : 0;
         cyc(1'b1, v);
         if (i == 127) begin
            chk("ext_neg_sym", sym2, 2'b10);
            chk("ext_neg_sv", sv2, 1);
         end
      end
      chk("ext_nowrap_sym", sym2, 2'b00);
      chk("ext_nowrap_sv", sv2, 1);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, s5[i]);
         if (i == 5) chk("skip_no_early", sv3, 0);
      end
      chk("skip_sym", sym3, 2'b11);
      chk("skip_sv", sv3, 1);
      chk("skip_b1", bout3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
